// File: rtl/stepper_seq.sv
// -----------------------------------------------------------------------------
// stepper_seq
// Unipolar/bipolar stepper motor phase sequencer. A move of NSTEPS steps is
// launched with START; one step is taken every PERIOD+1 clocks while EN=1.
// Each step advances a 3-bit phase index (half-step +/-1, full-step +/-2 with
// realignment from odd indices) and drives the four coils from a fixed table.
//
// Build option:
//   STEPPER_HOLD_EN  when defined, the coils keep driving the last phase while
//                    idle (EN=1, after at least one finished or stopped move),
//                    giving holding torque. When undefined, coils are off
//                    whenever the sequencer is not running.
//
// Parameters:
//   PRESC_W  width of the step-period prescaler and PERIOD
//   STEPS_W  width of NSTEPS and the remaining-step counter
//
// Ports:
//   CLK      system clock, rising edge
//   RST_N    asynchronous active-low reset
//   EN       1 = run and drive coils, 0 = pause and force coils off
//   START    one-cycle move request (honoured in IDLE only)
//   STOP     abort the current move
//   DIR      1 = forward, 0 = reverse (used at each step tick)
//   HALF     1 = half-step, 0 = full-step (used at each step tick)
//   PERIOD   clocks per step minus one, captured at START
//   NSTEPS   steps in the move, captured at START
//   A1..B2   registered coil drives
//   BUSY     high while running
//   STEP     one-cycle pulse when a new phase is applied
//   DONE     one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module stepper_seq #(
  parameter int PRESC_W = 16,
  parameter int STEPS_W = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               START,
  input  logic               STOP,
  input  logic               DIR,
  input  logic               HALF,
  input  logic [PRESC_W-1:0] PERIOD,
  input  logic [STEPS_W-1:0] NSTEPS,
  output logic               A1,
  output logic               A2,
  output logic               B1,
  output logic               B2,
  output logic               BUSY,
  output logic               STEP,
  output logic               DONE
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_reg,  state_next;
  logic [PRESC_W-1:0] presc_reg,  presc_next;
  logic [PRESC_W-1:0] period_reg, period_next;
  logic [STEPS_W-1:0] remain_reg, remain_next;
  logic [2:0]         idx_reg,    idx_next;
  logic [3:0]         coil_reg,   coil_next;
  logic               step_reg,   step_next;
  logic               done_reg,   done_next;
`ifdef STEPPER_HOLD_EN
  logic               hold_reg,   hold_next;
`endif

  // Coil pattern {A1,A2,B1,B2} for each phase index.
  function automatic logic [3:0] phase_coils(input logic [2:0] i);
    logic [3:0] c;
    case (i)
      3'd0:    c = 4'b0101;
      3'd1:    c = 4'b0100;
      3'd2:    c = 4'b1100;
      3'd3:    c = 4'b1000;
      3'd4:    c = 4'b1010;
      3'd5:    c = 4'b0010;
      3'd6:    c = 4'b0011;
      default: c = 4'b0001;
    endcase
    return c;
  endfunction

  // Half-step moves by one. Full-step moves by two from an even index; from
  // an odd index a single move lands on the neighbouring even index, which
  // realigns the sequence to two-coil phases.
  function automatic logic [2:0] advance(input logic [2:0] i,
                                         input logic       dir,
                                         input logic       half);
    logic [2:0] n;
    if (half || i[0]) begin
      n = dir ? (i + 3'd1) : (i - 3'd1);
    end else begin
      n = dir ? (i + 3'd2) : (i - 3'd2);
    end
    return n;
  endfunction

  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    period_next = period_reg;
    remain_next = remain_reg;
    idx_next    = idx_reg;
    step_next   = 1'b0;
    done_next   = 1'b0;
    coil_next   = 4'b0000;

    case (state_reg)
      IDLE: begin
        if (START) begin
          if (NSTEPS == '0) begin
            // Empty move completes immediately without entering RUN.
            done_next = 1'b1;
          end else begin
            state_next  = RUN;
            presc_next  = '0;
            period_next = PERIOD;
            remain_next = NSTEPS;
          end
        end
      end
      RUN: begin
        if (STOP) begin
          // Abort takes priority over a coincident tick.
          state_next = IDLE;
        end else if (remain_reg == '0) begin
          // Final step was applied last cycle; let it be seen for one cycle.
          state_next = IDLE;
        end else if (EN) begin
          if (presc_reg == period_reg) begin
            presc_next  = '0;
            idx_next    = advance(idx_reg, DIR, HALF);
            step_next   = 1'b1;
            remain_next = remain_reg - STEPS_W'(1);
            done_next   = (remain_reg == STEPS_W'(1));
          end else begin
            presc_next = presc_reg + PRESC_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

`ifdef STEPPER_HOLD_EN
    hold_next = hold_reg;
    if (state_reg == RUN && state_next == IDLE) begin
      hold_next = 1'b1;
    end
    if (EN && (state_next == RUN || hold_next)) begin
      coil_next = phase_coils(idx_next);
    end
`else
    if (EN && state_next == RUN) begin
      coil_next = phase_coils(idx_next);
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      presc_reg  <= '0;
      period_reg <= '0;
      remain_reg <= '0;
      idx_reg    <= 3'd0;
      coil_reg   <= 4'b0000;
      step_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      presc_reg  <= presc_next;
      period_reg <= period_next;
      remain_reg <= remain_next;
      idx_reg    <= idx_next;
      coil_reg   <= coil_next;
      step_reg   <= step_next;
      done_reg   <= done_next;
    end
  end

`ifdef STEPPER_HOLD_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_reg <= 1'b0;
    end else begin
      hold_reg <= hold_next;
    end
  end
`endif

  assign {A1, A2, B1, B2} = coil_reg;
  assign BUSY = (state_reg == RUN);
  assign STEP = step_reg;
  assign DONE = done_reg;

endmodule

// File: tb/tb_stepper_seq.sv
// -----------------------------------------------------------------------------
// tb_stepper_seq
// Scenario bench for stepper_seq. Each scenario pushes the expected step
// events (cycle after START, coil pattern, DONE flag) into a queue before the
// move is launched and pops them as STEP pulses appear. Inputs change on the
// falling edge; outputs are sampled on the falling edge. Define
// STEPPER_HOLD_EN for both bench and design to check the holding-torque build.
// -----------------------------------------------------------------------------
module tb_stepper_seq;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        EN = 1'b1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        DIR = 1'b1;
  logic        HALF = 1'b0;
  logic [15:0] PERIOD = '0;
  logic [15:0] NSTEPS = '0;
  logic        A1, A2, B1, B2, BUSY, STEP, DONE;

  typedef struct {
    int         at;
    logic [3:0] coils;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  stepper_seq #(.PRESC_W(16), .STEPS_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .START(START), .STOP(STOP),
    .DIR(DIR), .HALF(HALF), .PERIOD(PERIOD), .NSTEPS(NSTEPS),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2),
    .BUSY(BUSY), .STEP(STEP), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] idle_exp(input logic [3:0] c);
`ifdef STEPPER_HOLD_EN
    return c;
`else
    return 4'b0000 & c;
`endif
  endfunction

  task automatic launch(input int period, input int nsteps, input logic dir, input logic half);
    @(negedge CLK);
    PERIOD = 16'(period);
    NSTEPS = 16'(nsteps);
    DIR    = dir;
    HALF   = half;
    START  = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({A1, A2, B1, B2, BUSY, STEP, DONE} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=0000000", {A1, A2, B1, B2, BUSY, STEP, DONE});
    end else $display("reset outputs=%b", {A1, A2, B1, B2, BUSY, STEP, DONE});
    RST_N = 1'b1;
  endtask

  // Full-step forward from index 0, plus a START pulse mid-move that must be ignored.
  task automatic test_full_fwd();
    sb.push_back('{4,  4'b1100, 1'b0});
    sb.push_back('{8,  4'b1010, 1'b0});
    sb.push_back('{12, 4'b0011, 1'b0});
    sb.push_back('{16, 4'b0101, 1'b1});
    launch(3, 4, 1'b1, 1'b0);
    for (int n = 0; n <= 17; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (n == 0) begin
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL full_busy got=%b want=1", BUSY); end
      end
      if (n == 6) begin START = 1'b1; NSTEPS = 16'd1; PERIOD = 16'd0; end
      if (n == 7) START = 1'b0;
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL full_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL full_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("full step n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE);
        end
      end else if (DONE) begin
        checks++; errors++; $display("FAIL full_stray_done n=%0d got=1 want=0", n);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || {A1, A2, B1, B2} !== idle_exp(4'b0101) || sb.size() != 0) begin
      errors++;
      $display("FAIL full_idle got busy=%b coils=%b left=%0d want busy=0 coils=%b left=0", BUSY, {A1, A2, B1, B2}, sb.size(), idle_exp(4'b0101));
    end
    sb.delete();
  endtask

  // Half-step reverse, one step per clock, from index 0 to index 5.
  task automatic test_half_rev();
    sb.push_back('{1, 4'b0001, 1'b0});
    sb.push_back('{2, 4'b0011, 1'b0});
    sb.push_back('{3, 4'b0010, 1'b1});
    launch(0, 3, 1'b0, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL half_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL half_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("half step n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE);
        end
      end else if (DONE) begin
        checks++; errors++; $display("FAIL half_stray_done n=%0d got=1 want=0", n);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || {A1, A2, B1, B2} !== idle_exp(4'b0010) || sb.size() != 0) begin
      errors++;
      $display("FAIL half_idle got busy=%b coils=%b left=%0d want busy=0 coils=%b left=0", BUSY, {A1, A2, B1, B2}, sb.size(), idle_exp(4'b0010));
    end
    sb.delete();
  endtask

  // Half-step back to index 1, then full-step forward realigns to 2 then 4.
  task automatic test_mode_switch();
    sb.push_back('{2, 4'b1010, 1'b0});
    sb.push_back('{4, 4'b1000, 1'b0});
    sb.push_back('{6, 4'b1100, 1'b0});
    sb.push_back('{8, 4'b0100, 1'b1});
    for (int m = 0; m < 2; m++) begin
      if (m == 0) launch(1, 4, 1'b0, 1'b1);
      else begin
        sb.push_back('{1, 4'b1100, 1'b0});
        sb.push_back('{2, 4'b1010, 1'b1});
        launch(0, 2, 1'b1, 1'b0);
      end
      for (int n = 0; n <= 9; n++) begin
        @(negedge CLK);
        if (n == 0) START = 1'b0;
        if (STEP) begin
          checks++;
          if (sb.size() == 0) begin errors++; $display("FAIL mode_extra_step m=%0d n=%0d", m, n); end
          else begin
            e = sb.pop_front();
            if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
              errors++;
              $display("FAIL mode_step m=%0d got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", m, n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
            end else $display("mode m=%0d step n=%0d coils=%b done=%b", m, n, {A1, A2, B1, B2}, DONE);
          end
        end else if (DONE) begin
          checks++; errors++; $display("FAIL mode_stray_done m=%0d n=%0d got=1 want=0", m, n);
        end
      end
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL mode_missing m=%0d got left=%0d want 0", m, sb.size()); end
      sb.delete();
    end
  endtask

  // STOP coincident with the second tick; then an empty move.
  task automatic test_stop();
    sb.push_back('{3, 4'b0010, 1'b0});
    launch(2, 5, 1'b1, 1'b1);
    for (int n = 0; n <= 12; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (n == 5) STOP = 1'b1;
      if (n == 6) begin
        STOP = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || {A1, A2, B1, B2} !== idle_exp(4'b0010)) begin
          errors++;
          $display("FAIL stop_idle got busy=%b coils=%b want busy=0 coils=%b", BUSY, {A1, A2, B1, B2}, idle_exp(4'b0010));
        end
      end
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stop_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL stop_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("stop step n=%0d coils=%b", n, {A1, A2, B1, B2});
        end
      end else if (DONE) begin
        checks++; errors++; $display("FAIL stop_stray_done n=%0d got=1 want=0", n);
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stop_missing got left=%0d want 0", sb.size()); end
    sb.delete();
    launch(7, 0, 1'b1, 1'b1);
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if ({BUSY, STEP, DONE} !== 3'b001) begin
      errors++; $display("FAIL zero_done got busy/step/done=%b want 001", {BUSY, STEP, DONE});
    end else $display("zero move busy/step/done=%b", {BUSY, STEP, DONE});
    @(negedge CLK);
    checks++;
    if ({BUSY, STEP, DONE} !== 3'b000) begin
      errors++; $display("FAIL zero_after got busy/step/done=%b want 000", {BUSY, STEP, DONE});
    end
  endtask

  // EN low for 10 clocks mid-period: coils off, timing shifted by 10.
  task automatic test_en_pause();
    sb.push_back('{14, 4'b0011, 1'b0});
    sb.push_back('{18, 4'b0001, 1'b1});
    launch(3, 2, 1'b1, 1'b1);
    for (int n = 0; n <= 19; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (n == 1 || n == 13 || (n >= 3 && n <= 12)) begin
        checks++;
        if ({A1, A2, B1, B2} !== ((n >= 3 && n <= 12) ? 4'b0000 : 4'b0010)) begin
          errors++;
          $display("FAIL pause_coils n=%0d got=%b want=%b", n, {A1, A2, B1, B2}, (n >= 3 && n <= 12) ? 4'b0000 : 4'b0010);
        end
      end
      if (n == 2) EN = 1'b0;
      if (n == 12) EN = 1'b1;
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL pause_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL pause_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("pause step n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE);
        end
      end else if (DONE) begin
        checks++; errors++; $display("FAIL pause_stray_done n=%0d got=1 want=0", n);
      end
    end
    checks++;
    if (BUSY !== 1'b0 || {A1, A2, B1, B2} !== idle_exp(4'b0001) || sb.size() != 0) begin
      errors++;
      $display("FAIL pause_idle got busy=%b coils=%b left=%0d want busy=0 coils=%b left=0", BUSY, {A1, A2, B1, B2}, sb.size(), idle_exp(4'b0001));
    end
    sb.delete();
  endtask

  // Reset during a move; afterwards nothing happens until a new START, which
  // begins from index 0.
  task automatic test_reset_mid();
    sb.push_back('{2, 4'b0101, 1'b0});
    sb.push_back('{4, 4'b0100, 1'b0});
    launch(1, 6, 1'b1, 1'b1);
    for (int n = 0; n <= 4; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rmid_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL rmid_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("rmid step n=%0d coils=%b", n, {A1, A2, B1, B2});
        end
      end
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({A1, A2, B1, B2, BUSY, STEP, DONE} !== 7'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL rmid_async got=%b left=%0d want=0000000 left=0", {A1, A2, B1, B2, BUSY, STEP, DONE}, sb.size());
    end else $display("rmid reset outputs=%b", {A1, A2, B1, B2, BUSY, STEP, DONE});
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      checks++;
      if ({A1, A2, B1, B2, BUSY, STEP, DONE} !== 7'b0) begin
        errors++;
        $display("FAIL rmid_quiet n=%0d got=%b want=0000000", n, {A1, A2, B1, B2, BUSY, STEP, DONE});
      end
    end
    sb.delete();
    sb.push_back('{1, 4'b0100, 1'b1});
    launch(0, 1, 1'b1, 1'b1);
    for (int n = 0; n <= 2; n++) begin
      @(negedge CLK);
      if (n == 0) START = 1'b0;
      if (STEP) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rnew_extra_step n=%0d", n); end
        else begin
          e = sb.pop_front();
          if (n !== e.at || {A1, A2, B1, B2} !== e.coils || DONE !== e.done) begin
            errors++;
            $display("FAIL rnew_step got n=%0d coils=%b done=%b want n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE, e.at, e.coils, e.done);
          end else $display("rnew step n=%0d coils=%b done=%b", n, {A1, A2, B1, B2}, DONE);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rnew_missing got left=%0d want 0", sb.size()); end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_full_fwd();
    test_half_rev();
    test_mode_switch();
    test_stop();
    test_en_pause();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stepper_seq.md
STEPPER_SEQ -- requirements
Module: stepper_seq

Interface
REQ-001 SHALL have parameter PRESC_W, default 16, width of step-period prescaler and PERIOD input.
REQ-002 SHALL have parameter STEPS_W, default 16, width of step-count NSTEPS and internal remaining-step counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named CLK and RST_N.
REQ-004 CLK  input  1  system clock, all state on rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 EN  input  1  1 = run/drive; 0 = pause prescaler, force coils off.
REQ-007 START  input  1  one-cycle request to begin a move, sampled in IDLE only.
REQ-008 STOP  input  1  abort current move.
REQ-009 DIR  input  1  1 = forward (index +), 0 = reverse (index -); sampled at each step tick.
REQ-010 HALF  input  1  1 = half-step (8-phase), 0 = full-step (4-phase, two coils); sampled at each step tick.
REQ-011 PERIOD  input  PRESC_W  clocks per step minus 1, latched at START.
REQ-012 NSTEPS  input  STEPS_W  number of steps for the move, latched at START.
REQ-013 A1, A2, B1, B2  output  1 each  registered coil drives (orange, yellow, pink, blue).
REQ-014 BUSY  output  1  1 while in RUN.
REQ-015 STEP  output  1  one-cycle pulse in the cycle a new phase is applied.
REQ-016 DONE  output  1  one-cycle pulse on normal move completion.

Function
REQ-017 Phase index SHALL be 3 bits, wrapping mod 8; table {A1,A2,B1,B2}: 0=0101, 1=0100, 2=1100, 3=1000, 4=1010, 5=0010, 6=0011, 7=0001.
REQ-018 Half-step tick SHALL add +1/-1 to index per DIR.
REQ-019 Full-step tick SHALL add +2/-2 on even index; on odd index SHALL move to the adjacent even index in DIR direction (+1/-1), realigning.
REQ-020 FSM states SHALL be IDLE and RUN only.
REQ-021 IDLE->RUN on START=1 with NSTEPS!=0; prescaler cleared, PERIOD and NSTEPS latched, BUSY=1 next cycle.
REQ-022 START with NSTEPS=0 SHALL pulse DONE next cycle, remain IDLE, no step.
REQ-023 START while RUN SHALL be ignored.
REQ-024 In RUN with EN=1 prescaler SHALL count 0..PERIOD; at PERIOD a step tick occurs, prescaler returns to 0; first step PERIOD+1 clocks after entering RUN; PERIOD=0 gives one step per clock.
REQ-025 Step tick SHALL update index, pulse STEP, decrement remaining; tick making remaining 0 SHALL pulse DONE in the same cycle and return to IDLE next cycle.
REQ-026 STOP in RUN SHALL return to IDLE next cycle, no DONE; STOP coincident with a tick SHALL win (no index change, no STEP).
REQ-027 EN=0 SHALL freeze prescaler, index and remaining count, and force A1..B2=0; resuming EN=1 continues the count.
REQ-028 During RUN with EN=1, coil outputs SHALL equal table[index] registered.
REQ-029 DIR/HALF changes mid-move SHALL take effect at the next tick only.

Reset
REQ-030 RST_N low SHALL asynchronously force IDLE, index 0, prescaler 0, remaining 0, A1=A2=B1=B2=0, BUSY=STEP=DONE=0, hold flag cleared.
REQ-031 Reset mid-move SHALL abandon the move; no DONE after release.

Configuration
REQ-032 Macro STEPPER_HOLD_EN SHALL select idle coil behaviour.
REQ-033 With STEPPER_HOLD_EN defined: in IDLE with EN=1 and at least one completed or stopped move since reset, outputs SHALL hold table[index] (holding torque).
REQ-034 Without STEPPER_HOLD_EN: outputs SHALL be 0 whenever not in RUN.

Verification
REQ-035 Full-step fwd: HALF=0, DIR=1, PERIOD=3, NSTEPS=4 from index 0 -> coils 1100,1010,0011,0101, STEP every 4 clocks, DONE on 4th STEP.
REQ-036 Half-step rev: HALF=1, DIR=0, PERIOD=0, NSTEPS=3 from index 0 -> 0001,0011,0010 on consecutive clocks, index 5.
REQ-037 Mode switch: half-step to index 1, then HALF=0 DIR=1 NSTEPS=2 -> index 2 then 4 (1100, 1010).
REQ-038 STOP coincident with 2nd tick, PERIOD=2, NSTEPS=5 -> exactly one STEP, no DONE, BUSY=0 next cycle; START with NSTEPS=0 -> DONE only.
REQ-039 EN=0 for 10 clocks mid-period -> coils 0, step timing shifted by 10 clocks; run again with and without STEPPER_HOLD_EN -> idle coils table[index] vs 0000.
REQ-040 RST_N asserted mid-move -> all outputs 0 immediately, no DONE after release, next START begins from index 0.
